// File: rtl/f_fetch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : f_fetch_ctrl_if                                               |
// | Purpose  : Instruction-memory request bus between the fetch sequencer    |
// |            and the IM. A beat completes when im_req && im_ready.         |
// | Signals  : im_req   - request valid (master -> slave)                    |
// |            im_addr  - byte address of the word, [1:0]=0 (master->slave)  |
// |            im_ready - slave accepts and returns data this cycle          |
// |            im_rdata - read data, valid with the handshake                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface f_fetch_ctrl_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ready, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);
endinterface
`default_nettype wire

// File: rtl/f_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : f_fetch_ctrl                                                  |
// | Purpose  : F-stage sequencer. Drives npc/pc_we into the PC register,     |
// |            issues IM requests, holds the fetched instruction across      |
// |            D-stage stalls, arbitrates redirects (exception > eret >      |
// |            branch) and kills any in-flight fetch a redirect overtakes.   |
// | Ports    : clk, reset (async, active-low)                                |
// |            PC_F          current PC register value                       |
// |            stall         hold F/D                                        |
// |            br_taken/br_target, exc_req, eret_req/epc  redirect sources   |
// |            npc, pc_we    next PC and write enable (combinational)        |
// |            im            IM request bus (master side)                    |
// |            Instr_F, PC_I, instr_valid_F, adel_F  registered F outputs    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES   = 32'd16384
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [31:0] PC_F,
  input  wire logic        stall,
  input  wire logic        br_taken,
  input  wire logic [31:0] br_target,
  input  wire logic        exc_req,
  input  wire logic        eret_req,
  input  wire logic [31:0] epc,
  output logic      [31:0] npc,
  output logic             pc_we,
  f_fetch_ctrl_if.master   im,
  output logic      [31:0] Instr_F,
  output logic      [31:0] PC_I,
  output logic             instr_valid_F,
  output logic             adel_F
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_KILL  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] req_addr;
  logic [31:0] pc_plus4;
  logic [31:0] pc_off;
  logic [31:0] redir_pc;
  logic        pc_legal;
  logic        redir;
  logic        fetch_done;
  logic        req;

  assign pc_plus4 = PC_F + 32'd4;
  // Subtraction wraps for PC_F below the base, so both bounds are tested.
  assign pc_off   = PC_F - IM_BASE;
  assign pc_legal = (PC_F[1:0] == 2'b00) && (PC_F >= IM_BASE) && (pc_off < IM_BYTES);

  // A stalled branch is not taken yet; exception and eret override stall.
  assign redir    = exc_req || eret_req || (br_taken && !stall);
  assign redir_pc = exc_req ? HANDLER_PC : (eret_req ? epc : br_target);

  // An illegal PC completes immediately without touching the IM.
  assign fetch_done = (state == S_FETCH) && (!pc_legal || im.im_ready);

  assign im.im_req  = req;
  assign im.im_addr = req_addr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: begin
        if (redir) begin
          // Without a handshake the old request is still owed a response.
          state_nx = fetch_done ? S_FETCH : S_KILL;
        end else if (fetch_done && stall) begin
          state_nx = S_HOLD;
        end
      end
      S_HOLD:  if (redir || !stall) state_nx = S_FETCH;
      S_KILL:  if (im.im_ready) state_nx = S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic; reset forces the request and PC write inactive at once.
  always_comb begin
    pc_we = 1'b0;
    req   = 1'b0;
    npc   = redir ? redir_pc : pc_plus4;
    if (reset) begin
      case (state)
        S_FETCH: begin
          req   = pc_legal;
          pc_we = redir || (fetch_done && !stall);
        end
        S_HOLD:  pc_we = redir || !stall;
        S_KILL: begin
          req   = 1'b1;
          pc_we = redir;
        end
        default: begin
          pc_we = 1'b0;
          req   = 1'b0;
        end
      endcase
    end
  end

  // Request address and F-stage instruction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr      <= RESET_PC;
      Instr_F       <= 32'd0;
      PC_I          <= 32'd0;
      instr_valid_F <= 1'b0;
      adel_F        <= 1'b0;
    end else begin
      // The request address follows the PC register into every FETCH entry,
      // so it matches PC_F for the whole FETCH residency.
      if (state_nx == S_FETCH) begin
        req_addr <= pc_we ? npc : PC_F;
      end
      case (state)
        S_FETCH: begin
          if (redir) begin
            instr_valid_F <= 1'b0;
            adel_F        <= 1'b0;
          end else if (fetch_done) begin
            Instr_F       <= pc_legal ? im.im_rdata : 32'd0;
            PC_I          <= pc_legal ? req_addr : PC_F;
            adel_F        <= !pc_legal;
            instr_valid_F <= 1'b1;
          end else if (!stall) begin
            // The previous instruction was consumed by D this cycle.
            instr_valid_F <= 1'b0;
          end
        end
        S_HOLD: if (redir || !stall) instr_valid_F <= 1'b0;
        S_KILL: instr_valid_F <= 1'b0;
        default: instr_valid_F <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_f_fetch_ctrl                                               |
// | Purpose  : Directed table-driven bench for f_fetch_ctrl with a PC        |
// |            register model and an IM returning addr ^ 0xDEAD0000.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_f_fetch_ctrl;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        rdy;
    logic        e_we;
    logic [31:0] e_npc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_ins;
    logic [31:0] e_pci;
    logic        e_adel;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc_f;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] npc;
  logic        pc_we;
  logic        rdy;
  logic [31:0] Instr_F;
  logic [31:0] PC_I;
  logic        instr_valid_F;
  logic        adel_F;

  int vectors;
  int miscompares;

  f_fetch_ctrl_if bus();

  assign bus.im_ready = rdy;
  assign bus.im_rdata = bus.im_addr ^ 32'hDEAD_0000;

  f_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .PC_F         (pc_f),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .npc          (npc),
    .pc_we        (pc_we),
    .im           (bus),
    .Instr_F      (Instr_F),
    .PC_I         (PC_I),
    .instr_valid_F(instr_valid_F),
    .adel_F       (adel_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_f <= 32'h0000_3000;
    else if (pc_we) pc_f <= npc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive one cycle of inputs, compare at the falling edge, return just after the next rising edge.
  task automatic apply(input vec_t t, input int idx);
    logic ok;
    stall = t.stall; br_taken = t.br; br_target = t.bt;
    exc_req = t.exc; eret_req = t.eret; epc = t.epc; rdy = t.rdy;
    @(negedge clk);
    ok = (pc_we === t.e_we) && (!t.e_we || npc === t.e_npc) &&
         (bus.im_req === t.e_req) && (bus.im_addr === t.e_addr) &&
         (instr_valid_F === t.e_val) &&
         (!t.e_val || (Instr_F === t.e_ins && PC_I === t.e_pci && adel_F === t.e_adel));
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL vec%0d: got pc_we=%b npc=%h req=%b addr=%h val=%b ins=%h pci=%h adel=%b; want pc_we=%b npc=%h req=%b addr=%h val=%b ins=%h pci=%h adel=%b",
               idx, pc_we, npc, bus.im_req, bus.im_addr, instr_valid_F, Instr_F, PC_I, adel_F,
               t.e_we, t.e_npc, t.e_req, t.e_addr, t.e_val, t.e_ins, t.e_pci, t.e_adel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    vectors++;
    if (bus.im_req !== 1'b0 || pc_we !== 1'b0 || instr_valid_F !== 1'b0 || Instr_F !== 32'd0 ||
        PC_I !== 32'd0 || adel_F !== 1'b0 || bus.im_addr !== 32'h0000_3000) begin
      miscompares++;
      $display("FAIL %s: got req=%b pc_we=%b val=%b ins=%h pci=%h adel=%b addr=%h; want 0 0 0 0 0 0 00003000",
               name, bus.im_req, pc_we, instr_valid_F, Instr_F, PC_I, adel_F, bus.im_addr);
    end
  endtask

  vec_t tbl [37];

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0; rdy = 1'b0;

    //          stall br bt            exc eret epc           rdy  we npc           req addr          val ins           pci           adel
    // streaming fetch
    tbl[0]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0,   0, 32'h0,         0, 32'h3000,     0, 32'h0,         32'h0,         0};
    tbl[1]  = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3004,      1, 32'h3000,     0, 32'h0,         32'h0,         0};
    tbl[2]  = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3008,      1, 32'h3004,     1, 32'hDEAD3000,  32'h3000,      0};
    tbl[3]  = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h300C,      1, 32'h3008,     1, 32'hDEAD3004,  32'h3004,      0};
    // branch while IM not ready: old request held, data discarded
    tbl[4]  = '{0, 1, 32'h3100,      0, 0, 32'h0,         0,   1, 32'h3100,      1, 32'h300C,     1, 32'hDEAD3008,  32'h3008,      0};
    tbl[5]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0,   0, 32'h0,         1, 32'h300C,     0, 32'h0,         32'h0,         0};
    tbl[6]  = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h300C,     0, 32'h0,         32'h0,         0};
    // stall for four cycles on a returned instruction
    tbl[7]  = '{1, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h3100,     0, 32'h0,         32'h0,         0};
    tbl[8]  = '{1, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h3100,     1, 32'hDEAD3100,  32'h3100,      0};
    tbl[9]  = '{1, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h3100,     1, 32'hDEAD3100,  32'h3100,      0};
    tbl[10] = '{1, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h3100,     1, 32'hDEAD3100,  32'h3100,      0};
    tbl[11] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3104,      0, 32'h3100,     1, 32'hDEAD3100,  32'h3100,      0};
    tbl[12] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3108,      1, 32'h3104,     0, 32'h0,         32'h0,         0};
    // exception beats stall and branch
    tbl[13] = '{1, 1, 32'h5000,      1, 0, 32'h0,         1,   1, 32'h4180,      1, 32'h3108,     1, 32'hDEAD3104,  32'h3104,      0};
    tbl[14] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h4184,      1, 32'h4180,     0, 32'h0,         32'h0,         0};
    // eret to a misaligned EPC
    tbl[15] = '{0, 0, 32'h0,         0, 1, 32'h3002,      1,   1, 32'h3002,      1, 32'h4184,     1, 32'hDEAD4180,  32'h4180,      0};
    tbl[16] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3006,      0, 32'h3002,     0, 32'h0,         32'h0,         0};
    tbl[17] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h300A,      0, 32'h3006,     1, 32'h0,         32'h3002,      1};
    tbl[18] = '{0, 1, 32'h3200,      0, 0, 32'h0,         1,   1, 32'h3200,      0, 32'h300A,     1, 32'h0,         32'h3006,      1};
    tbl[19] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3204,      1, 32'h3200,     0, 32'h0,         32'h0,         0};
    // stalled branch is ignored, then taken from HOLD
    tbl[20] = '{1, 1, 32'h3300,      0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h3204,     1, 32'hDEAD3200,  32'h3200,      0};
    tbl[21] = '{0, 1, 32'h3300,      0, 0, 32'h0,         1,   1, 32'h3300,      0, 32'h3204,     1, 32'hDEAD3204,  32'h3204,      0};
    tbl[22] = '{0, 0, 32'h0,         0, 0, 32'h0,         0,   0, 32'h0,         1, 32'h3300,     0, 32'h0,         32'h0,         0};
    tbl[23] = '{1, 0, 32'h0,         0, 0, 32'h0,         0,   0, 32'h0,         1, 32'h3300,     0, 32'h0,         32'h0,         0};
    tbl[24] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3304,      1, 32'h3300,     0, 32'h0,         32'h0,         0};
    // window top: last legal word, then first illegal one
    tbl[25] = '{0, 1, 32'h6FFC,      0, 0, 32'h0,         1,   1, 32'h6FFC,      1, 32'h3304,     1, 32'hDEAD3300,  32'h3300,      0};
    tbl[26] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h7000,      1, 32'h6FFC,     0, 32'h0,         32'h0,         0};
    tbl[27] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h7004,      0, 32'h7000,     1, 32'hDEAD6FFC,  32'h6FFC,      0};
    // window bottom: one word below base, then base
    tbl[28] = '{0, 0, 32'h0,         0, 1, 32'h2FFC,      1,   1, 32'h2FFC,      0, 32'h7004,     1, 32'h0,         32'h7000,      1};
    tbl[29] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3000,      0, 32'h2FFC,     0, 32'h0,         32'h0,         0};
    tbl[30] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h3004,      1, 32'h3000,     1, 32'h0,         32'h2FFC,      1};
    // PC+4 wraps past 2^32
    tbl[31] = '{0, 0, 32'h0,         0, 1, 32'hFFFFFFFC,  1,   1, 32'hFFFFFFFC,  1, 32'h3004,     1, 32'hDEAD3000,  32'h3000,      0};
    tbl[32] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h0,         0, 32'hFFFFFFFC, 0, 32'h0,         32'h0,         0};
    tbl[33] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h4,         0, 32'h0,        1, 32'h0,         32'hFFFFFFFC,  1};
    tbl[34] = '{0, 0, 32'h0,         1, 0, 32'h0,         0,   1, 32'h4180,      0, 32'h4,        1, 32'h0,         32'h0,         1};
    tbl[35] = '{0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h4184,      1, 32'h4180,     0, 32'h0,         32'h0,         0};
    tbl[36] = '{0, 0, 32'h0,         0, 0, 32'h0,         0,   0, 32'h0,         1, 32'h4184,     1, 32'hDEAD4180,  32'h4180,      0};

    @(negedge clk);
    check_reset_state("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 37; i++) apply(tbl[i], i);

    // Reset dropped mid-cycle while a request is pending
    stall = 1'b0; br_taken = 1'b0; exc_req = 1'b0; eret_req = 1'b0; rdy = 1'b0;
    #2;
    vectors++;
    if (bus.im_req !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_req: got req=%b want 1", bus.im_req);
    end
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply('{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0,    0, 32'h3000, 0, 32'h0,        32'h0,    0}, 100);
    apply('{0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h3004, 1, 32'h3000, 0, 32'h0,        32'h0,    0}, 101);
    apply('{0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h3008, 1, 32'h3004, 1, 32'hDEAD3000, 32'h3000, 0}, 102);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
